// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC stored-program core: opcode values and FSM state encoding.
package risc_spm_pkg;

    localparam int OPC_NOP = 0;
    localparam int OPC_ADD = 1;
    localparam int OPC_SUB = 2;
    localparam int OPC_AND = 3;
    localparam int OPC_NOT = 4;
    localparam int OPC_RD  = 5;
    localparam int OPC_WR  = 6;
    localparam int OPC_BR  = 7;
    localparam int OPC_BRZ = 8;
    localparam int OPC_BRC = 9;
    localparam int OPC_HLT = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXEC  = 3'd3,
        S_OPND  = 3'd4,
        S_RD1   = 3'd5,
        S_WR1   = 3'd6,
        S_HALT  = 3'd7
    } state_e;

    // Register-index width; a single-register file still needs one select bit.
    function automatic int reg_aw(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/risc_spm_alu.sv
// Combinational ALU: ADD/SUB/AND/NOT with zero and carry/borrow outputs.
module risc_spm_alu
    import risc_spm_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_c,
    output logic [WORD_W-1:0] o_result,
    output logic              o_z,
    output logic              o_c
);

    // Result and carry selection; AND/NOT pass the old carry through.
    always_comb begin
        o_result = i_a;
        o_c      = i_c;
        case (i_op)
            OP_W'(OPC_ADD): {o_c, o_result} = {1'b0, i_a} + {1'b0, i_b};
            OP_W'(OPC_SUB): begin
                o_result = i_a - i_b;
                o_c      = (i_b > i_a);
            end
            OP_W'(OPC_AND): o_result = i_a & i_b;
            OP_W'(OPC_NOT): o_result = ~i_b;
            default: begin
                o_result = i_a;
                o_c      = i_c;
            end
        endcase
    end

    assign o_z = (o_result == {WORD_W{1'b0}});

endmodule

// File: rtl/risc_spm_core_p.sv
// Multi-cycle stored-program core with start/halt control, carry flag, branch/halt opcodes,
// illegal-opcode trap and a ready/ack memory port.
module risc_spm_core_p
    import risc_spm_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int NREG   = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              err,
    output logic              zflag,
    output logic              cflag,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] ir_out
);

    localparam int REG_AW = reg_aw(NREG);

    state_e            r_state;
    state_e            w_state_nx;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_ir;
    logic [WORD_W-1:0] r_ar;
    logic [WORD_W-1:0] r_regs [NREG];
    logic              r_z;
    logic              r_c;
    logic              r_err;

    logic [OP_W-1:0]   w_op;
    logic [REG_AW-1:0] w_src;
    logic [REG_AW-1:0] w_dst;
    logic [WORD_W-1:0] w_a;
    logic [WORD_W-1:0] w_b;
    logic [WORD_W-1:0] w_alu_res;
    logic              w_alu_z;
    logic              w_alu_c;
    logic              w_illegal;
    logic              w_br_skip;

    assign w_op      = r_ir[WORD_W-1 -: OP_W];
    assign w_src     = r_ir[2*REG_AW-1:REG_AW];
    assign w_dst     = r_ir[REG_AW-1:0];
    assign w_a       = r_regs[w_dst];
    assign w_b       = r_regs[w_src];
    assign w_illegal = (w_op > OP_W'(OPC_HLT));
    // A conditional branch that is not taken skips over its operand word.
    assign w_br_skip = ((w_op == OP_W'(OPC_BRZ)) && !r_z) ||
                       ((w_op == OP_W'(OPC_BRC)) && !r_c);

    risc_spm_alu #(.WORD_W(WORD_W), .OP_W(OP_W)) u_alu (
        .i_op     (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .i_c      (r_c),
        .o_result (w_alu_res),
        .o_z      (w_alu_z),
        .o_c      (w_alu_c)
    );

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = start ? S_FETCH : S_IDLE;
            S_FETCH: w_state_nx = mem_ack ? S_DEC : S_FETCH;
            S_DEC: begin
                case (w_op)
                    OP_W'(OPC_NOP): w_state_nx = S_FETCH;
                    OP_W'(OPC_ADD), OP_W'(OPC_SUB),
                    OP_W'(OPC_AND), OP_W'(OPC_NOT): w_state_nx = S_EXEC;
                    OP_W'(OPC_RD), OP_W'(OPC_WR),
                    OP_W'(OPC_BR):  w_state_nx = S_OPND;
                    OP_W'(OPC_BRZ), OP_W'(OPC_BRC):
                        w_state_nx = w_br_skip ? S_FETCH : S_OPND;
                    OP_W'(OPC_HLT): w_state_nx = S_HALT;
                    default:        w_state_nx = S_HALT;
                endcase
            end
            S_EXEC: w_state_nx = S_FETCH;
            S_OPND: begin
                if (!mem_ack) begin
                    w_state_nx = S_OPND;
                end else if (w_op == OP_W'(OPC_RD)) begin
                    w_state_nx = S_RD1;
                end else if (w_op == OP_W'(OPC_WR)) begin
                    w_state_nx = S_WR1;
                end else begin
                    w_state_nx = S_FETCH;
                end
            end
            S_RD1:  w_state_nx = mem_ack ? S_FETCH : S_RD1;
            S_WR1:  w_state_nx = mem_ack ? S_FETCH : S_WR1;
            S_HALT: w_state_nx = start ? S_FETCH : S_HALT;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Memory port decoded from the state so it drops as soon as the state does.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = {WORD_W{1'b0}};
        case (r_state)
            S_FETCH, S_OPND: mem_req = 1'b1;
            S_RD1: begin
                mem_req  = 1'b1;
                mem_addr = r_ar;
            end
            S_WR1: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_ar;
                mem_wdata = w_b;
            end
            default: mem_req = 1'b0;
        endcase
    end

    // State, datapath registers and flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= {WORD_W{1'b0}};
            r_ir    <= {WORD_W{1'b0}};
            r_ar    <= {WORD_W{1'b0}};
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {WORD_W{1'b0}};
            end
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + WORD_W'(1);
                    end
                end
                S_DEC: begin
                    if (w_br_skip) begin
                        r_pc <= r_pc + WORD_W'(1);
                    end
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_regs[w_dst] <= w_alu_res;
                    r_z           <= w_alu_z;
                    r_c           <= w_alu_c;
                end
                S_OPND: begin
                    if (mem_ack) begin
                        if ((w_op == OP_W'(OPC_RD)) || (w_op == OP_W'(OPC_WR))) begin
                            r_ar <= mem_rdata;
                            r_pc <= r_pc + WORD_W'(1);
                        end else begin
                            r_pc <= mem_rdata;
                        end
                    end
                end
                S_RD1: begin
                    if (mem_ack) begin
                        r_regs[w_dst] <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted = (r_state == S_HALT);
    assign err    = r_err;
    assign zflag  = r_z;
    assign cflag  = r_c;
    assign pc_out = r_pc;
    assign ir_out = r_ir;

endmodule

// File: tb/tb_risc_spm_core_p.sv
// Directed bench for risc_spm_core_p with a behavioural memory that has programmable ack latency.
module tb_risc_spm_core_p;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       halted;
    logic       err;
    logic       zflag;
    logic       cflag;
    logic [7:0] pc_out;
    logic [7:0] ir_out;

    logic [7:0] mem [256];
    int         rd_delay = 0;
    int         wr_delay = 0;
    int         wait_cnt = 0;
    logic       hold_en = 1'b0;
    logic [7:0] hold_addr = 8'h00;
    logic       force_ack = 1'b0;
    int         wr_count = 0;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;
    logic [7:0] watch_addr = 8'hFF;
    int         watch_cnt = 0;

    int checks = 0;
    int failures = 0;

    risc_spm_core_p #(.WORD_W(8), .NREG(4), .OP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .err       (err),
        .zflag     (zflag),
        .cflag     (cflag),
        .pc_out    (pc_out),
        .ir_out    (ir_out)
    );

    always #5 clk = ~clk;

    assign mem_ack = force_ack |
                     (mem_req && !(hold_en && (mem_addr == hold_addr)) &&
                      (wait_cnt >= (mem_we ? wr_delay : rd_delay)));
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            wait_cnt <= 0;
            if (mem_we) begin
                wr_count     <= wr_count + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
            end
            if (mem_addr == watch_addr) watch_cnt <= watch_cnt + 1;
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset;
        rst = 1'b0; start = 1'b0; force_ack = 1'b0; hold_en = 1'b0;
        rd_delay = 0; wr_delay = 0;
        tick; tick;
        rst = 1'b1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_halted(input int budget, input string nm);
        int n = 0;
        while (!halted && n < budget) begin
            tick;
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL %s_halt: halted=%b required 1 within %0d cycles", nm, halted, budget);
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({pc_out, ir_out} !== 16'h0000) begin
            failures++; $display("FAIL reset_pc_ir: pc=%h ir=%h required 00 00", pc_out, ir_out);
        end
        checks++;
        if ({mem_req, halted, err, zflag, cflag} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_flags: req=%b halted=%b err=%b z=%b c=%b required all 0",
                     mem_req, halted, err, zflag, cflag);
        end
    endtask

    task automatic test_rd;
        clear_mem;
        mem[0] = 8'h50; mem[1] = 8'h10; mem[2] = 8'hA0; mem[8'h10] = 8'hFF;
        do_reset;
        pulse_start;
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === 8'h00)) begin
            failures++; $display("FAIL rd_first_fetch: req=%b addr=%h required 1 00", mem_req, mem_addr);
        end
        repeat (4) tick;
        checks++;
        if (dut.r_regs[0] !== 8'hFF) begin
            failures++; $display("FAIL rd_r0: got %h required ff", dut.r_regs[0]);
        end
        checks++;
        if (!(pc_out === 8'h02 && mem_req === 1'b1 && mem_addr === 8'h02)) begin
            failures++;
            $display("FAIL rd_cycles: pc=%h req=%b addr=%h required 02 1 02", pc_out, mem_req, mem_addr);
        end
        wait_halted(20, "rd");
    endtask

    task automatic test_alu_and_resume;
        clear_mem;
        mem[0] = 8'h51; mem[1] = 8'h20; mem[2] = 8'h52; mem[3] = 8'h21;
        mem[4] = 8'h19; mem[5] = 8'hA0; mem[6] = 8'h2A; mem[7] = 8'hA0;
        mem[8'h20] = 8'hF0; mem[8'h21] = 8'h20;
        do_reset;
        pulse_start;
        wait_halted(60, "add");
        checks++;
        if (!(dut.r_regs[1] === 8'h10 && cflag === 1'b1 && zflag === 1'b0)) begin
            failures++;
            $display("FAIL add_result: r1=%h c=%b z=%b required 10 1 0", dut.r_regs[1], cflag, zflag);
        end
        checks++;
        if (pc_out !== 8'h06) begin
            failures++; $display("FAIL hlt_pc: got %h required 06", pc_out);
        end
        pulse_start;
        checks++;
        if (!(halted === 1'b0 && mem_req === 1'b1 && mem_addr === 8'h06)) begin
            failures++;
            $display("FAIL resume: halted=%b req=%b addr=%h required 0 1 06", halted, mem_req, mem_addr);
        end
        wait_halted(20, "sub");
        checks++;
        if (!(dut.r_regs[2] === 8'h00 && zflag === 1'b1 && cflag === 1'b0)) begin
            failures++;
            $display("FAIL sub_result: r2=%h z=%b c=%b required 00 1 0", dut.r_regs[2], zflag, cflag);
        end
    endtask

    task automatic test_branch;
        int w0;
        // NOP takes two cycles from fetch to the next fetch
        clear_mem;
        mem[0] = 8'h00; mem[1] = 8'hA0;
        do_reset;
        pulse_start;
        tick; tick;
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === 8'h01)) begin
            failures++; $display("FAIL nop_cycles: req=%b addr=%h required 1 01", mem_req, mem_addr);
        end
        wait_halted(20, "nop");
        // SUB R0,R0 sets Z, then BRZ taken to 0x40
        clear_mem;
        mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'h40; mem[8'h40] = 8'hA0;
        do_reset;
        pulse_start;
        repeat (6) tick;
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === 8'h40 && zflag === 1'b1)) begin
            failures++;
            $display("FAIL brz_taken: req=%b addr=%h z=%b required 1 40 1", mem_req, mem_addr, zflag);
        end
        wait_halted(20, "brz_taken");
        checks++;
        if (pc_out !== 8'h41) begin
            failures++; $display("FAIL brz_taken_pc: got %h required 41", pc_out);
        end
        // BRZ with Z clear skips the operand without reading it
        clear_mem;
        mem[0] = 8'h80; mem[1] = 8'h55; mem[2] = 8'hA0;
        watch_addr = 8'h01;
        do_reset;
        w0 = watch_cnt;
        pulse_start;
        tick; tick;
        checks++;
        if (!(pc_out === 8'h02 && mem_req === 1'b1 && mem_addr === 8'h02)) begin
            failures++;
            $display("FAIL brz_not_taken: pc=%h req=%b addr=%h required 02 1 02", pc_out, mem_req, mem_addr);
        end
        wait_halted(20, "brz_nt");
        checks++;
        if (watch_cnt !== w0) begin
            failures++; $display("FAIL brz_operand_read: reads=%0d required 0", watch_cnt - w0);
        end
        watch_addr = 8'hFF;
        // NOT R0 -> FF, ADD R0,R0 -> FE with carry, BRC taken to 0x30
        clear_mem;
        mem[0] = 8'h40; mem[1] = 8'h10; mem[2] = 8'h90; mem[3] = 8'h30; mem[8'h30] = 8'hA0;
        do_reset;
        pulse_start;
        wait_halted(30, "brc");
        checks++;
        if (!(pc_out === 8'h31 && dut.r_regs[0] === 8'hFE && cflag === 1'b1 && zflag === 1'b0)) begin
            failures++;
            $display("FAIL brc_taken: pc=%h r0=%h c=%b z=%b required 31 fe 1 0",
                     pc_out, dut.r_regs[0], cflag, zflag);
        end
    endtask

    task automatic test_wr_wait;
        int w0;
        int n;
        clear_mem;
        mem[0] = 8'h53; mem[1] = 8'h22; mem[2] = 8'h6C; mem[3] = 8'h80; mem[4] = 8'hA0;
        mem[8'h22] = 8'hA5;
        do_reset;
        wr_delay = 3;
        w0 = wr_count;
        pulse_start;
        n = 0;
        while (mem_we !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        checks++;
        if (mem_we !== 1'b1) begin
            failures++; $display("FAIL wr_seen: we=%b required 1 within 30 cycles", mem_we);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 8'h80 && mem_wdata === 8'hA5)) begin
                failures++;
                $display("FAIL wr_hold_%0d: req=%b we=%b addr=%h wdata=%h required 1 1 80 a5",
                         k, mem_req, mem_we, mem_addr, mem_wdata);
            end
            tick;
        end
        checks++;
        if (!(mem_we === 1'b0 && mem_addr === 8'h04)) begin
            failures++; $display("FAIL wr_release: we=%b addr=%h required 0 04", mem_we, mem_addr);
        end
        wait_halted(20, "wr");
        checks++;
        if (!((wr_count - w0) === 1 && last_wr_addr === 8'h80 && last_wr_data === 8'hA5)) begin
            failures++;
            $display("FAIL wr_mem: writes=%0d addr=%h data=%h required 1 80 a5",
                     wr_count - w0, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_illegal;
        int reqs;
        clear_mem;
        mem[0] = 8'hF0; mem[1] = 8'hA0;
        do_reset;
        pulse_start;
        wait_halted(10, "illegal");
        checks++;
        if (!(err === 1'b1 && pc_out === 8'h01)) begin
            failures++; $display("FAIL illegal_err: err=%b pc=%h required 1 01", err, pc_out);
        end
        reqs = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_req === 1'b1) reqs++;
            tick;
        end
        checks++;
        if (reqs !== 0) begin
            failures++; $display("FAIL illegal_quiet: req cycles=%0d required 0", reqs);
        end
        pulse_start;
        wait_halted(10, "illegal_resume");
        checks++;
        if (!(err === 1'b1 && pc_out === 8'h02)) begin
            failures++; $display("FAIL err_sticky: err=%b pc=%h required 1 02", err, pc_out);
        end
    endtask

    task automatic test_reset_midaccess;
        int n;
        clear_mem;
        mem[0] = 8'h51; mem[1] = 8'h30; mem[8'h30] = 8'h77;
        do_reset;
        hold_en = 1'b1;
        hold_addr = 8'h30;
        pulse_start;
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr === 8'h30) && n < 20) begin
            tick;
            n++;
        end
        tick;
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === 8'h30)) begin
            failures++; $display("FAIL rd1_pending: req=%b addr=%h required 1 30", mem_req, mem_addr);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (!(mem_req === 1'b0 && pc_out === 8'h00 && ir_out === 8'h00 && dut.r_ar === 8'h00)) begin
            failures++;
            $display("FAIL midreset: req=%b pc=%h ir=%h ar=%h required 0 00 00 00",
                     mem_req, pc_out, ir_out, dut.r_ar);
        end
        rst = 1'b1;
        hold_en = 1'b0;
        force_ack = 1'b1;
        repeat (3) tick;
        force_ack = 1'b0;
        checks++;
        if (!(mem_req === 1'b0 && pc_out === 8'h00 && ir_out === 8'h00 && dut.r_regs[1] === 8'h00)) begin
            failures++;
            $display("FAIL late_ack: req=%b pc=%h ir=%h r1=%h required 0 00 00 00",
                     mem_req, pc_out, ir_out, dut.r_regs[1]);
        end
    endtask

    initial begin
        clear_mem;
        test_reset;
        test_rd;
        test_alu_and_resume;
        test_branch;
        test_wr_wait;
        test_illegal;
        test_reset_midaccess;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
